// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: arbitration states, requester ids
// and the read-return tag carried through the latency pipe.
package sram_port_arbiter_pkg;

  localparam int ADDR_W     = 18;
  localparam int DATA_W     = 16;
  localparam int LOCK_CNT_W = 7;

  typedef enum logic [1:0] {
    S_ARB_IDLE,
    S_ARB_LOCK_UART,
    S_ARB_LOCK_M1
  } arb_state_type;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_VGA,
    REQ_UART,
    REQ_M1
  } req_id_type;

  typedef struct packed {
    logic       valid;
    req_id_type id;
  } read_tag_type;

  function automatic logic tag_is(input read_tag_type tag, input req_id_type id);
    return tag.valid && (tag.id == id);
  endfunction

endpackage

// File: rtl/sram_port_arbiter_read_tag_pipe.sv
// Delay line for read tags: a tag entered with a granted read emerges exactly
// READ_LATENCY cycles later, alongside the controller's read data.
module sram_port_arbiter_read_tag_pipe
  import sram_port_arbiter_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  read_tag_type i_tag,
  output read_tag_type o_tag
);

  read_tag_type r_tag_p [READ_LATENCY];

  // The clear drops in-flight tags so no stale rvalid survives a reset.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_tag_p[i] <= '0;
      end
    end else begin
      r_tag_p[0] <= i_tag;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag_p[i] <= r_tag_p[i-1];
      end
    end
  end

  assign o_tag = r_tag_p[READ_LATENCY-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM controller port between VGA, UART and M1: VGA first, then
// the lock owner, then UART/M1 round-robin; read data is steered by tag.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int MAX_LOCK     = 64
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              SRAM_ready,
  input  logic [DATA_W-1:0] SRAM_read_data,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic [DATA_W-1:0] SRAM_write_data,
  output logic              SRAM_we_n,
  input  logic              VGA_req,
  input  logic              VGA_we_n,
  input  logic [ADDR_W-1:0] VGA_address,
  input  logic [DATA_W-1:0] VGA_write_data,
  input  logic              UART_req,
  input  logic              UART_we_n,
  input  logic [ADDR_W-1:0] UART_address,
  input  logic [DATA_W-1:0] UART_write_data,
  input  logic              UART_lock,
  input  logic              M1_req,
  input  logic              M1_we_n,
  input  logic [ADDR_W-1:0] M1_address,
  input  logic [DATA_W-1:0] M1_write_data,
  input  logic              M1_lock,
  output logic              VGA_gnt,
  output logic              UART_gnt,
  output logic              M1_gnt,
  output logic              VGA_rvalid,
  output logic              UART_rvalid,
  output logic              M1_rvalid,
  output logic [DATA_W-1:0] read_data
);

  arb_state_type         r_state;
  arb_state_type         w_state_next;
  req_id_type            r_rr_ptr;
  req_id_type            r_block_id;
  req_id_type            w_winner;
  logic [LOCK_CNT_W-1:0] r_lock_cnt;
  logic                  w_lock_done;
  logic                  w_forced_release;
  logic                  w_uart_ok;
  logic                  w_m1_ok;
  logic                  w_rd_granted;
  read_tag_type          w_tag_in;
  read_tag_type          w_tag_out;

  // r_block_id holds back a just-released owner for one cycle so the other side gets in.
  always_comb begin
    w_uart_ok = UART_req && !((r_block_id == REQ_UART) && M1_req);
    w_m1_ok   = M1_req   && !((r_block_id == REQ_M1)   && UART_req);
    w_winner  = REQ_NONE;
    if (!SRAM_ready || !Resetn) begin
      w_winner = REQ_NONE;
    end else if (VGA_req) begin
      w_winner = REQ_VGA;
    end else if ((r_state == S_ARB_LOCK_UART) && UART_req) begin
      w_winner = REQ_UART;
    end else if ((r_state == S_ARB_LOCK_M1) && M1_req) begin
      w_winner = REQ_M1;
    end else if (w_uart_ok && w_m1_ok) begin
      w_winner = r_rr_ptr;
    end else if (w_uart_ok) begin
      w_winner = REQ_UART;
    end else if (w_m1_ok) begin
      w_winner = REQ_M1;
    end
  end

  always_comb begin
    VGA_gnt         = (w_winner == REQ_VGA);
    UART_gnt        = (w_winner == REQ_UART);
    M1_gnt          = (w_winner == REQ_M1);
    SRAM_address    = '0;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    w_rd_granted    = 1'b0;
    unique case (w_winner)
      REQ_VGA: begin
        SRAM_address    = VGA_address;
        SRAM_write_data = VGA_write_data;
        SRAM_we_n       = VGA_we_n;
        w_rd_granted    = VGA_we_n;
      end
      REQ_UART: begin
        SRAM_address    = UART_address;
        SRAM_write_data = UART_write_data;
        SRAM_we_n       = UART_we_n;
        w_rd_granted    = UART_we_n;
      end
      REQ_M1: begin
        SRAM_address    = M1_address;
        SRAM_write_data = M1_write_data;
        SRAM_we_n       = M1_we_n;
        w_rd_granted    = M1_we_n;
      end
      default: ;
    endcase
  end

  assign w_lock_done = (r_lock_cnt == LOCK_CNT_W'(MAX_LOCK - 1));

  always_comb begin
    w_state_next     = r_state;
    w_forced_release = 1'b0;
    unique case (r_state)
      S_ARB_IDLE: begin
        if ((w_winner == REQ_UART) && UART_lock) begin
          w_state_next = S_ARB_LOCK_UART;
        end else if ((w_winner == REQ_M1) && M1_lock) begin
          w_state_next = S_ARB_LOCK_M1;
        end
      end
      S_ARB_LOCK_UART: begin
        if (!UART_lock) begin
          w_state_next = S_ARB_IDLE;
        end else if (w_lock_done) begin
          w_state_next     = S_ARB_IDLE;
          w_forced_release = 1'b1;
        end
      end
      S_ARB_LOCK_M1: begin
        if (!M1_lock) begin
          w_state_next = S_ARB_IDLE;
        end else if (w_lock_done) begin
          w_state_next     = S_ARB_IDLE;
          w_forced_release = 1'b1;
        end
      end
      default: w_state_next = S_ARB_IDLE;
    endcase
  end

  // Lock counter runs on every locked cycle, VGA pre-emption included.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= S_ARB_IDLE;
      r_rr_ptr   <= REQ_UART;
      r_lock_cnt <= '0;
      r_block_id <= REQ_NONE;
    end else begin
      r_state <= w_state_next;
      if (w_winner == REQ_UART) begin
        r_rr_ptr <= REQ_M1;
      end else if (w_winner == REQ_M1) begin
        r_rr_ptr <= REQ_UART;
      end
      if (r_state == S_ARB_IDLE) begin
        r_lock_cnt <= '0;
      end else begin
        r_lock_cnt <= r_lock_cnt + 1'b1;
      end
      if (w_forced_release) begin
        r_block_id <= (r_state == S_ARB_LOCK_UART) ? REQ_UART : REQ_M1;
      end else begin
        r_block_id <= REQ_NONE;
      end
    end
  end

  assign w_tag_in.valid = w_rd_granted;
  assign w_tag_in.id    = w_winner;

  sram_port_arbiter_read_tag_pipe #(
    .READ_LATENCY (READ_LATENCY)
  ) u_read_tag_pipe (
    .Clock  (Clock),
    .Resetn (Resetn),
    .i_tag  (w_tag_in),
    .o_tag  (w_tag_out)
  );

  // Return stage: tag and controller data line up READ_LATENCY cycles after the grant.
  assign VGA_rvalid  = tag_is(w_tag_out, REQ_VGA);
  assign UART_rvalid = tag_is(w_tag_out, REQ_UART);
  assign M1_rvalid   = tag_is(w_tag_out, REQ_M1);
  assign read_data   = SRAM_read_data;

endmodule
